// File: rtl/mmu_pkg.sv
// Shared encodings for the MMU data responder: funct3 access sizes, FSM states,
// data width and the size/offset alignment helper.
package mmu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_INV = 3'b111
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } mmu_state_e;

    // Natural alignment check; size[1:0] selects the access width for signed and unsigned forms alike
    function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] off);
        logic mis;
        case (size[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off[1:0] != 2'b00);
            2'b11:   mis = (off != 3'b000);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mmu_lane_align.sv
// Combinational lane steering: store data/strobe placement and load extract/extend.
// Lanes past byte 7 are simply lost, so misaligned loads see zeros in their upper bytes.
module mmu_lane_align
    import mmu_pkg::*;
(
    input  logic [2:0]      size,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] st_data,
    output logic [7:0]      st_strb,
    output logic [XLEN-1:0] ld_data
);

    logic [5:0]      shamt_s;
    logic [XLEN-1:0] ld_shift_s;

    // Store placement, strobe generation and load extraction
    always_comb begin
        shamt_s    = {offset, 3'b000};
        st_data    = wdata << shamt_s;
        ld_shift_s = rdata >> shamt_s;

        case (size[1:0])
            2'b00:   st_strb = 8'h01 << offset;
            2'b01:   st_strb = 8'h03 << offset;
            2'b10:   st_strb = 8'h0F << offset;
            default: st_strb = 8'hFF;
        endcase

        case (size)
            SZ_B:    ld_data = {{56{ld_shift_s[7]}},  ld_shift_s[7:0]};
            SZ_H:    ld_data = {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};
            SZ_W:    ld_data = {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};
            SZ_D:    ld_data = ld_shift_s;
            SZ_BU:   ld_data = {56'h0, ld_shift_s[7:0]};
            SZ_HU:   ld_data = {48'h0, ld_shift_s[15:0]};
            SZ_WU:   ld_data = {32'h0, ld_shift_s[31:0]};
            default: ld_data = 64'h0;
        endcase
    end

endmodule

// File: rtl/mmu_data_resp.sv
// Data-memory responder: latches one MEM-stage request, runs it on the 64-bit bus, pulses ready.
// Optional feature macro: MMU_MISALIGN_CHECK_EN (reject misaligned accesses without a bus cycle).
module mmu_data_resp
    import mmu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [2:0]      mem_size,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic            mmu_data_ready,
    output logic [XLEN-1:0] mmu_rdata,
    output logic            mmu_data_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wstrb,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mmu_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       size_q, size_d;
    logic [2:0]       off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [XLEN-1:0]  bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]  bus_wdata_q, bus_wdata_d;
    logic [7:0]       bus_wstrb_q, bus_wstrb_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;

    logic             reject_s;
    logic [2:0]       align_size_s;
    logic [2:0]       align_off_s;
    logic [XLEN-1:0]  st_data_s;
    logic [7:0]       st_strb_s;
    logic [XLEN-1:0]  ld_data_s;

    // In IDLE the aligner shapes the incoming store; afterwards it decodes the returning load
    always_comb begin
        if (state_q == ST_IDLE) begin
            align_size_s = mem_size;
            align_off_s  = mem_addr[2:0];
        end else begin
            align_size_s = size_q;
            align_off_s  = off_q;
        end
    end

    mmu_lane_align u_lane_align (
        .size    (align_size_s),
        .offset  (align_off_s),
        .wdata   (mem_wdata),
        .rdata   (bus_rdata),
        .st_data (st_data_s),
        .st_strb (st_strb_s),
        .ld_data (ld_data_s)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        rdata_d     = 64'h0;
        reject_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    we_d     = mem_we;
                    size_d   = mem_size;
                    off_d    = mem_addr[2:0];
                    reject_s = (mem_size == SZ_INV);
`ifdef MMU_MISALIGN_CHECK_EN
                    reject_s = reject_s | is_misaligned(mem_size, mem_addr[2:0]);
`endif
                    if (reject_s) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_we;
                        bus_addr_d  = {mem_addr[63:3], 3'b000};
                        bus_wdata_d = st_data_s;
                        bus_wstrb_d = mem_we ? st_strb_s : 8'h00;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack in the final watchdog cycle still completes normally
                if (bus_ack) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = we_q ? 64'h0 : ld_data_s;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding bus request at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= 3'b000;
            off_q       <= 3'b000;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 64'h0;
            bus_wdata_q <= 64'h0;
            bus_wstrb_q <= 8'h00;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 64'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mmu_data_ready = ready_q;
    assign mmu_data_err   = err_q;
    assign mmu_rdata      = rdata_q;
    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_wdata      = bus_wdata_q;
    assign bus_wstrb      = bus_wstrb_q;

endmodule
